// File: rtl/dma_timing_ctrl.sv
// Channel arbiter and SI/S0/S1-S4/SC transfer sequencer for an 8237A-style DMA
// controller. Every output is a register loaded from the state being entered.
module dma_timing_ctrl (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  DREQ,
    input  logic        HLDA,
    input  logic        EOP_N,
    input  logic [7:0]  commandReg,
    input  logic [23:0] modeReg,
    input  logic [3:0]  maskReg,
    input  logic [3:0]  requestReg,
    input  logic [3:0]  currWordZero,
    output logic        HRQ,
    output logic        AEN,
    output logic        ADSTB,
    output logic [3:0]  DACK,
    output logic        IOR_N_o,
    output logic        IOW_N_o,
    output logic        MEMR_N_o,
    output logic        MEMW_N_o,
    output logic        Program,
    output logic [1:0]  activeCh,
    output logic        enCurrAddr,
    output logic        ldCurrAddrTemp,
    output logic        ldCurrWordTemp,
    output logic        ldTempCurrAddr,
    output logic        ldTempCurrWord,
    output logic [3:0]  TC,
    output logic [3:0]  valid_DREQ
);
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CFG_W  = 6;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    typedef enum logic [2:0] {
        ST_SI, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_SC
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   prio_ptr_q, prio_ptr_d, ch_d;
    logic [CH_W-1:0]   arb_base, arb_idx, arb_win;
    logic              arb_hit;
    logic [NUM_CH-1:0] req_c, ch_onehot;
    logic [CFG_W-1:0]  ch_cfg;
    logic              is_write, is_read;
    logic [1:0]        xfer_mode;
    logic              eop_seen_q, eop_seen_d, term_q, term_d;
    logic              in_xfer, rd_phase, wr_phase;
    logic              hrq_d, aen_d, adstb_d, program_d;
    logic              ior_n_d, iow_n_d, memr_n_d, memw_n_d;
    logic              en_curr_addr_d, ld_to_temp_d, ld_from_temp_d;
    logic [NUM_CH-1:0] dack_d, tc_d;
    logic              unused_bits;

    assign unused_bits = ^{commandReg[5], commandReg[3], commandReg[1:0], ch_cfg[3:2]};

    assign req_c = (requestReg | (DREQ ^ {NUM_CH{commandReg[6]}}))
                 & ~maskReg & {NUM_CH{~commandReg[2]}};

    // Mode fields of the channel in service; type 11 falls through as verify
    always_comb begin
        case (activeCh)
            2'd0:    ch_cfg = modeReg[5:0];
            2'd1:    ch_cfg = modeReg[11:6];
            2'd2:    ch_cfg = modeReg[17:12];
            default: ch_cfg = modeReg[23:18];
        endcase
    end

    assign is_write  = (ch_cfg[1:0] == 2'b01);
    assign is_read   = (ch_cfg[1:0] == 2'b10);
    assign xfer_mode = ch_cfg[5:4];

    // Scan from lowest to highest priority so the highest-priority hit wins
    always_comb begin
        arb_base = commandReg[4] ? prio_ptr_q : '0;
        arb_idx  = '0;
        arb_win  = '0;
        arb_hit  = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            arb_idx = arb_base + CH_W'(i);
            if (req_c[arb_idx]) begin
                arb_win = arb_idx;
                arb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = activeCh;
        prio_ptr_d = prio_ptr_q;
        eop_seen_d = eop_seen_q;
        term_d     = term_q;
        case (state_q)
            ST_SI: begin
                if (arb_hit) begin
                    state_d = ST_S0;
                    ch_d    = arb_win;
                end
            end
            ST_S0: begin
                if (HLDA) begin
                    state_d = (xfer_mode == MODE_CASCADE) ? ST_SC : ST_S1;
                end else if (!req_c[activeCh]) begin
                    state_d = ST_SI;
                end
            end
            ST_S1: begin
                eop_seen_d = 1'b0;
                term_d     = 1'b0;
                state_d    = HLDA ? ST_S2 : ST_SI;
            end
            ST_S2: begin
                eop_seen_d = eop_seen_q | ~EOP_N;
                state_d    = HLDA ? ST_S3 : ST_SI;
            end
            ST_S3: begin
                if (HLDA) begin
                    state_d = ST_S4;
                    term_d  = currWordZero[activeCh] | eop_seen_q | ~EOP_N;
                end else begin
                    state_d = ST_SI;
                end
            end
            ST_S4: begin
                if (!term_q && (xfer_mode == MODE_BLOCK ||
                                (xfer_mode == MODE_DEMAND && req_c[activeCh]))) begin
                    state_d = ST_S1;
                end else begin
                    state_d    = ST_SI;
                    prio_ptr_d = activeCh + CH_W'(1);
                end
            end
            ST_SC: begin
                if (!req_c[activeCh]) state_d = ST_SI;
            end
            default: state_d = ST_SI;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        in_xfer        = state_d inside {ST_S1, ST_S2, ST_S3, ST_S4};
        rd_phase       = state_d inside {ST_S2, ST_S3};
        wr_phase       = (state_d == ST_S3);
        ch_onehot      = NUM_CH'(1) << ch_d;
        hrq_d          = (state_d != ST_SI);
        aen_d          = in_xfer;
        adstb_d        = (state_d == ST_S1);
        en_curr_addr_d = (state_d == ST_S1);
        program_d      = (state_d == ST_SI) && !HLDA;
        dack_d         = ((in_xfer || state_d == ST_SC) ? ch_onehot : '0)
                       ^ {NUM_CH{~commandReg[7]}};
        ior_n_d        = ~(is_write && rd_phase);
        memr_n_d       = ~(is_read && rd_phase);
        memw_n_d       = ~(is_write && wr_phase);
        iow_n_d        = ~(is_read && wr_phase);
        ld_to_temp_d   = (state_q == ST_S2) && (state_d == ST_S3);
        ld_from_temp_d = (state_d == ST_S4);
        tc_d           = ((state_q == ST_S3) && (state_d == ST_S4) && term_d) ? ch_onehot : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q        <= ST_SI;
            prio_ptr_q     <= '0;
            eop_seen_q     <= 1'b0;
            term_q         <= 1'b0;
            activeCh       <= '0;
            HRQ            <= 1'b0;
            AEN            <= 1'b0;
            ADSTB          <= 1'b0;
            DACK           <= '0;
            IOR_N_o        <= 1'b1;
            IOW_N_o        <= 1'b1;
            MEMR_N_o       <= 1'b1;
            MEMW_N_o       <= 1'b1;
            Program        <= 1'b0;
            enCurrAddr     <= 1'b0;
            ldCurrAddrTemp <= 1'b0;
            ldCurrWordTemp <= 1'b0;
            ldTempCurrAddr <= 1'b0;
            ldTempCurrWord <= 1'b0;
            TC             <= '0;
            valid_DREQ     <= '0;
        end else begin
            state_q        <= state_d;
            prio_ptr_q     <= prio_ptr_d;
            eop_seen_q     <= eop_seen_d;
            term_q         <= term_d;
            activeCh       <= ch_d;
            HRQ            <= hrq_d;
            AEN            <= aen_d;
            ADSTB          <= adstb_d;
            DACK           <= dack_d;
            IOR_N_o        <= ior_n_d;
            IOW_N_o        <= iow_n_d;
            MEMR_N_o       <= memr_n_d;
            MEMW_N_o       <= memw_n_d;
            Program        <= program_d;
            enCurrAddr     <= en_curr_addr_d;
            ldCurrAddrTemp <= ld_to_temp_d;
            ldCurrWordTemp <= ld_to_temp_d;
            ldTempCurrAddr <= ld_from_temp_d;
            ldTempCurrWord <= ld_from_temp_d;
            TC             <= tc_d;
            valid_DREQ     <= req_c;
        end
    end
endmodule
